huffman_stream_packer: RTL and testbench

- Parametrised successor to the single-block Huffman controller.
- Accepts 8x8 zigzag-ordered coefficient blocks for NUM_COMP interleaved components and performs per-component DC prediction and AC run-length scanning, including ZRL and EOB.
- Issues one symbol request per cycle to the external Huffman encoder and receives its code in the same cycle.
- Packs the variable-length codes MSB-first into a byte stream with JPEG 0xFF/0x00 stuffing and end-of-scan padding.
- Sits between the zigzag stage and the output byte FIFO.

---
 rtl/huffman_stream_packer_if.sv | 41 ++++
 rtl/huffman_stream_packer.sv | 245 ++++++++++++++++++++++++
 tb/tb_huffman_stream_packer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/huffman_stream_packer_if.sv
// rtl/huffman_stream_packer_if.sv - Block input, encoder request/response and byte output signals of the packer
interface huffman_stream_packer_if #(
    parameter int COEF_W   = 8,
    parameter int NUM_COMP = 3,
    parameter int CODE_W   = 24
);
    localparam int CW = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1;

    logic                   blk_valid;
    logic                   blk_ready;
    logic [64*COEF_W-1:0]   blk_data;
    logic                   blk_last;

    logic                   enc_req;
    logic                   enc_is_dc;
    logic [CW-1:0]          enc_comp;
    logic [3:0]             enc_run;
    logic [COEF_W:0]        enc_value;
    logic                   enc_eob;
    logic                   enc_zrl;
    logic [CODE_W-1:0]      enc_code;
    logic [4:0]             enc_len;

    logic                   byte_valid;
    logic [7:0]             byte_data;
    logic                   byte_ready;

    logic                   busy;

    modport master (
        input  blk_valid, blk_data, blk_last, enc_code, enc_len, byte_ready,
        output blk_ready, enc_req, enc_is_dc, enc_comp, enc_run, enc_value,
               enc_eob, enc_zrl, byte_valid, byte_data, busy
    );

    modport slave (
        output blk_valid, blk_data, blk_last, enc_code, enc_len, byte_ready,
        input  blk_ready, enc_req, enc_is_dc, enc_comp, enc_run, enc_value,
               enc_eob, enc_zrl, byte_valid, byte_data, busy
    );
endinterface

// File: rtl/huffman_stream_packer.sv
// rtl/huffman_stream_packer.sv - DC prediction, AC run-length scan and JPEG byte packing; HUFF_EOI_MARKER_EN appends FF D9 at end of scan
module huffman_stream_packer #(
    parameter int COEF_W   = 8,
    parameter int NUM_COMP = 3,
    parameter int CODE_W   = 24,
    parameter int ACC_W    = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    huffman_stream_packer_if.master bus
);
    localparam int CW = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1;
    localparam int FW = $clog2(ACC_W + 1);
    localparam int VW = COEF_W + 1;
    localparam logic [ACC_W-1:0] TOP_MASK = {8'hFF, {(ACC_W-8){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_DC, S_AC, S_FLUSH, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [64*COEF_W-1:0] blk_q, blk_d;
    logic                 last_q, last_d;
    logic [5:0]           last_nz_q, last_nz_d;
    logic [6:0]           k_q, k_d;
    logic [3:0]           run_q, run_d;
    logic [CW-1:0]        comp_q, comp_d;
    logic [COEF_W-1:0]    pred_q [NUM_COMP];
    logic [COEF_W-1:0]    pred_d [NUM_COMP];
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic                 stuff_q, stuff_d;
`ifdef HUFF_EOI_MARKER_EN
    logic                 eoi_idx_q, eoi_idx_d;
`endif

    logic [COEF_W-1:0]    coef_k, coef_dc, pred_cur;
    logic                 req, req_dc, req_eob, req_zrl;
    logic [3:0]           req_run;
    logic [VW-1:0]        req_value;
    logic                 accept, byte_avail, drain, eoi_active, blk_end;
    logic [7:0]           top_byte, out_byte;
    logic [ACC_W-1:0]     code_bits;

    function automatic logic [5:0] find_last_nz(input logic [64*COEF_W-1:0] d);
        logic [5:0] r;
        r = '0;
        for (int k = 1; k < 64; k++) begin
            if (d[k*COEF_W +: COEF_W] != '0) r = 6'(k);
        end
        return r;
    endfunction

    assign coef_k   = blk_q[int'(k_q[5:0])*COEF_W +: COEF_W];
    assign coef_dc  = blk_q[COEF_W-1:0];
    assign pred_cur = pred_q[comp_q];

    // Symbol decode: stalls simply hold these because k/run/state do not move.
    always_comb begin
        req       = 1'b0;
        req_dc    = 1'b0;
        req_eob   = 1'b0;
        req_zrl   = 1'b0;
        req_run   = '0;
        req_value = '0;
        case (state_q)
            S_DC: begin
                req       = 1'b1;
                req_dc    = 1'b1;
                req_value = {coef_dc[COEF_W-1], coef_dc} - {pred_cur[COEF_W-1], pred_cur};
            end
            S_AC: begin
                if (k_q > {1'b0, last_nz_q}) begin
                    if (last_nz_q != 6'd63) begin
                        req     = 1'b1;
                        req_eob = 1'b1;
                    end
                end else if (coef_k == '0) begin
                    if (run_q == 4'd15) begin
                        req     = 1'b1;
                        req_zrl = 1'b1;
                        req_run = 4'd15;
                    end
                end else begin
                    req       = 1'b1;
                    req_run   = run_q;
                    req_value = {coef_k[COEF_W-1], coef_k};
                end
            end
            default: ;
        endcase
    end

    assign accept     = req && (int'(fill_q) + int'(bus.enc_len) <= ACC_W);
    assign code_bits  = ACC_W'(bus.enc_code) & ~({ACC_W{1'b1}} << bus.enc_len);
    assign top_byte   = acc_q[ACC_W-1 -: 8];
    assign byte_avail = (fill_q >= FW'(8)) && !stuff_q;
    assign drain      = byte_avail && bus.byte_ready;
`ifdef HUFF_EOI_MARKER_EN
    assign eoi_active = (state_q == S_DONE);
`else
    assign eoi_active = 1'b0;
`endif

    always_comb begin
        out_byte = 8'h00;
        if (eoi_active) begin
`ifdef HUFF_EOI_MARKER_EN
            out_byte = eoi_idx_q ? 8'hD9 : 8'hFF;
`endif
        end else if (!stuff_q && byte_avail) begin
            out_byte = top_byte;
        end
    end

    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        last_d    = last_q;
        last_nz_d = last_nz_q;
        k_d       = k_q;
        run_d     = run_q;
        comp_d    = comp_q;
        pred_d    = pred_q;
        acc_d     = acc_q;
        fill_d    = fill_q;
        stuff_d   = stuff_q;
        blk_end   = 1'b0;
`ifdef HUFF_EOI_MARKER_EN
        eoi_idx_d = eoi_idx_q;
`endif

        // Drain first, then append below whatever remains.
        if (stuff_q && bus.byte_ready) stuff_d = 1'b0;
        if (drain) begin
            acc_d  = acc_q << 8;
            fill_d = fill_q - FW'(8);
            if (top_byte == 8'hFF) stuff_d = 1'b1;
        end
        if (accept) begin
            acc_d  = acc_d | (code_bits << (ACC_W - int'(fill_d) - int'(bus.enc_len)));
            fill_d = fill_d + FW'(bus.enc_len);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.blk_valid) begin
                    blk_d     = bus.blk_data;
                    last_d    = bus.blk_last;
                    last_nz_d = find_last_nz(bus.blk_data);
                    state_d   = S_DC;
                end
            end
            S_DC: begin
                if (accept) begin
                    pred_d[comp_q] = coef_dc;
                    k_d            = 7'd1;
                    run_d          = '0;
                    state_d        = S_AC;
                end
            end
            S_AC: begin
                if (k_q > {1'b0, last_nz_q}) begin
                    if (last_nz_q == 6'd63 || accept) blk_end = 1'b1;
                end else if (coef_k == '0 && run_q != 4'd15) begin
                    run_d = run_q + 4'd1;
                    k_d   = k_q + 7'd1;
                end else if (accept) begin
                    run_d = '0;
                    k_d   = k_q + 7'd1;
                end
                if (blk_end) begin
                    comp_d  = (comp_q == CW'(NUM_COMP-1)) ? '0 : comp_q + 1'b1;
                    state_d = last_q ? S_FLUSH : S_IDLE;
                end
            end
            S_FLUSH: begin
                if (fill_q == '0 && !stuff_q) begin
                    for (int i = 0; i < NUM_COMP; i++) pred_d[i] = '0;
                    comp_d  = '0;
                    state_d = S_DONE;
                end else if (fill_q != '0 && fill_q < FW'(8)) begin
                    // Pad the final partial byte with 1s.
                    acc_d  = acc_q | (TOP_MASK & ({ACC_W{1'b1}} >> fill_q));
                    fill_d = FW'(8);
                end
            end
            S_DONE: begin
`ifdef HUFF_EOI_MARKER_EN
                if (bus.byte_ready) begin
                    eoi_idx_d = ~eoi_idx_q;
                    if (eoi_idx_q) state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            blk_q     <= '0;
            last_q    <= 1'b0;
            last_nz_q <= '0;
            k_q       <= '0;
            run_q     <= '0;
            comp_q    <= '0;
            for (int i = 0; i < NUM_COMP; i++) pred_q[i] <= '0;
            acc_q     <= '0;
            fill_q    <= '0;
            stuff_q   <= 1'b0;
`ifdef HUFF_EOI_MARKER_EN
            eoi_idx_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            blk_q     <= blk_d;
            last_q    <= last_d;
            last_nz_q <= last_nz_d;
            k_q       <= k_d;
            run_q     <= run_d;
            comp_q    <= comp_d;
            pred_q    <= pred_d;
            acc_q     <= acc_d;
            fill_q    <= fill_d;
            stuff_q   <= stuff_d;
`ifdef HUFF_EOI_MARKER_EN
            eoi_idx_q <= eoi_idx_d;
`endif
        end
    end

    assign bus.blk_ready  = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.enc_req    = req;
    assign bus.enc_is_dc  = req_dc;
    assign bus.enc_comp   = req ? comp_q : '0;
    assign bus.enc_run    = req_run;
    assign bus.enc_value  = req_value;
    assign bus.enc_eob    = req_eob;
    assign bus.enc_zrl    = req_zrl;
    assign bus.byte_valid = eoi_active || stuff_q || byte_avail;
    assign bus.byte_data  = out_byte;
endmodule

// File: tb/tb_huffman_stream_packer.sv
// tb/tb_huffman_stream_packer.sv - Directed table-driven bench for huffman_stream_packer with a mock Huffman encoder
module tb_huffman_stream_packer;
    localparam int COEF_W   = 8;
    localparam int NUM_COMP = 3;
    localparam int CODE_W   = 24;
    localparam int ACC_W    = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    huffman_stream_packer_if #(.COEF_W(COEF_W), .NUM_COMP(NUM_COMP), .CODE_W(CODE_W)) bus ();

    huffman_stream_packer #(
        .COEF_W(COEF_W), .NUM_COMP(NUM_COMP), .CODE_W(CODE_W), .ACC_W(ACC_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    logic [23:0] dc_code, ac_code;
    logic [4:0]  dc_len, ac_len;
    logic        br_rand, br_val;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [17:0] sym_log[$];
    logic [7:0]  byte_log[$];
    logic [7:0]  exp_bytes[$];

    always_comb begin
        if (bus.enc_is_dc) begin
            bus.enc_code = dc_code;
            bus.enc_len  = dc_len;
        end else begin
            bus.enc_code = ac_code;
            bus.enc_len  = ac_len;
        end
    end

    initial begin
        bus.byte_ready = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            bus.byte_ready = br_rand ? 1'($urandom_range(0, 1)) : br_val;
        end
    end

    always @(negedge clock) begin
        if (bus.enc_req)
            sym_log.push_back({bus.enc_is_dc, bus.enc_eob, bus.enc_zrl, bus.enc_comp,
                               bus.enc_run, bus.enc_value});
        if (bus.byte_valid && bus.byte_ready) byte_log.push_back(bus.byte_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        int          dc;
        int          k1;
        int          v1;
        int          k2;
        int          v2;
        logic        last;
        int          n;
        logic [5:0][17:0] syms;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [17:0] mk(input logic d, input logic e, input logic z,
                                       input int comp, input int run, input int val);
        return {d, e, z, 2'(comp), 4'(run), 9'(val)};
    endfunction
    function automatic logic [17:0] s_dc(input int c, input int v);  return mk(1, 0, 0, c, 0, v); endfunction
    function automatic logic [17:0] s_ac(input int c, input int r, input int v); return mk(0, 0, 0, c, r, v); endfunction
    function automatic logic [17:0] s_eob(input int c); return mk(0, 1, 0, c, 0, 0);  endfunction
    function automatic logic [17:0] s_zrl(input int c); return mk(0, 0, 1, c, 15, 0); endfunction

    function automatic vec_t mkv(input int dc, input int k1, input int v1, input int k2, input int v2,
                                 input logic last, input int n,
                                 input logic [17:0] s0, input logic [17:0] s1, input logic [17:0] s2,
                                 input logic [17:0] s3, input logic [17:0] s4, input logic [17:0] s5);
        vec_t v;
        v.dc = dc; v.k1 = k1; v.v1 = v1; v.k2 = k2; v.v2 = v2; v.last = last; v.n = n;
        v.syms[0] = s0; v.syms[1] = s1; v.syms[2] = s2;
        v.syms[3] = s3; v.syms[4] = s4; v.syms[5] = s5;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send_block(input int dc, input int k1, input int v1, input int k2, input int v2,
                              input logic last);
        logic [64*COEF_W-1:0] d;
        d = '0;
        d[7:0] = 8'(dc);
        if (k1 != 0) d[k1*COEF_W +: COEF_W] = 8'(v1);
        if (k2 != 0) d[k2*COEF_W +: COEF_W] = 8'(v2);
        @(negedge clock);
        bus.blk_data  = d;
        bus.blk_last  = last;
        bus.blk_valid = 1'b1;
        @(negedge clock);
        bus.blk_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while (bus.blk_ready !== 1'b1 && cyc < 2000) begin
            @(negedge clock);
            cyc++;
        end
        check({name, "_idle"}, 64'(bus.blk_ready), 64'd1);
    endtask

    task automatic compare_bytes(input string name);
        check({name, "_nbytes"}, 64'(byte_log.size()), 64'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size(); i++)
            check($sformatf("%s_byte%0d", name, i),
                  (i < byte_log.size()) ? 64'(byte_log[i]) : 64'hFFFF, 64'(exp_bytes[i]));
    endtask

    initial begin
        reset = 1'b1;
        bus.blk_valid = 1'b0; bus.blk_data = '0; bus.blk_last = 1'b0;
        dc_code = '0; dc_len = '0; ac_code = '0; ac_len = '0;
        br_rand = 1'b0; br_val = 1'b1;

        vecs[0] = mkv(5,    1, -3, 0, 0, 0, 3, s_dc(0, 5),    s_ac(0, 0, -3), s_eob(0), 0, 0, 0);
        vecs[1] = mkv(5,    0, 0,  0, 0, 0, 2, s_dc(1, 5),    s_eob(1), 0, 0, 0, 0);
        vecs[2] = mkv(5,    0, 0,  0, 0, 0, 2, s_dc(2, 5),    s_eob(2), 0, 0, 0, 0);
        vecs[3] = mkv(7,    0, 0,  0, 0, 0, 2, s_dc(0, 2),    s_eob(0), 0, 0, 0, 0);
        vecs[4] = mkv(5,   20, 1,  0, 0, 0, 4, s_dc(1, 0),    s_zrl(1), s_ac(1, 3, 1), s_eob(1), 0, 0);
        vecs[5] = mkv(-128,63, 4,  0, 0, 0, 5, s_dc(2, -133), s_zrl(2), s_zrl(2), s_zrl(2), s_ac(2, 14, 4), 0);
        vecs[6] = mkv(127,  1, 1,  2, -1, 1, 4, s_dc(0, 120), s_ac(0, 0, 1), s_ac(0, 0, -1), s_eob(0), 0, 0);
        vecs[7] = mkv(3,    0, 0,  0, 0, 0, 2, s_dc(0, 3),    s_eob(0), 0, 0, 0, 0);

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_state", 64'({bus.blk_ready, bus.busy, bus.enc_req, bus.byte_valid, bus.byte_data}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));

        for (int i = 0; i < 8; i++) begin
            sym_log.delete();
            send_block(vecs[i].dc, vecs[i].k1, vecs[i].v1, vecs[i].k2, vecs[i].v2, vecs[i].last);
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("vec%0d_nsym", i), 64'(sym_log.size()), 64'(vecs[i].n));
            for (int j = 0; j < vecs[i].n; j++)
                check($sformatf("vec%0d_sym%0d", i, j),
                      (j < sym_log.size()) ? 64'(sym_log[j]) : 64'h3FFFF, 64'(vecs[i].syms[j]));
        end

        // 0xFF code forces a stuffed 0x00 while the sink throttles randomly.
        byte_log.delete(); exp_bytes.delete();
        exp_bytes.push_back(8'hFF); exp_bytes.push_back(8'h00);
`ifdef HUFF_EOI_MARKER_EN
        exp_bytes.push_back(8'hFF); exp_bytes.push_back(8'hD9);
`endif
        dc_code = 24'hFF; dc_len = 5'd8; ac_len = 5'd0; br_rand = 1'b1;
        send_block(0, 0, 0, 0, 0, 1);
        wait_idle("stuff");
        compare_bytes("stuff");

        // Three residual bits 101 pad to 0xBF.
        byte_log.delete(); exp_bytes.delete();
        exp_bytes.push_back(8'hBF);
`ifdef HUFF_EOI_MARKER_EN
        exp_bytes.push_back(8'hFF); exp_bytes.push_back(8'hD9);
`endif
        dc_code = 24'h5; dc_len = 5'd3;
        send_block(0, 0, 0, 0, 0, 1);
        wait_idle("pad");
        compare_bytes("pad");

        // Sink blocked with 24-bit codes: second symbol must stall.
        byte_log.delete(); exp_bytes.delete();
        br_rand = 1'b0; br_val = 1'b0;
        dc_code = 24'hABCDEF; dc_len = 5'd24; ac_code = 24'h123456; ac_len = 5'd24;
        exp_bytes.push_back(8'hAB); exp_bytes.push_back(8'hCD); exp_bytes.push_back(8'hEF);
        for (int i = 0; i < 3; i++) begin
            exp_bytes.push_back(8'h12); exp_bytes.push_back(8'h34); exp_bytes.push_back(8'h56);
        end
`ifdef HUFF_EOI_MARKER_EN
        exp_bytes.push_back(8'hFF); exp_bytes.push_back(8'hD9);
`endif
        send_block(1, 1, 1, 2, 1, 1);
        repeat (20) @(negedge clock);
        check("stall_req", 64'({bus.enc_req, bus.enc_is_dc}), 64'({1'b1, 1'b0}));
        check("stall_byte_hold", 64'({bus.byte_valid, bus.byte_data}), 64'({1'b1, 8'hAB}));
        br_val = 1'b1;
        wait_idle("stall");
        compare_bytes("stall");

        // Reset in the middle of an AC scan.
        dc_len = 5'd0; ac_len = 5'd0;
        send_block(2, 63, 1, 0, 0, 0);
        repeat (5) @(negedge clock);
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_reset_state", 64'({bus.busy, bus.blk_ready, bus.enc_req, bus.byte_valid}),
              64'({1'b0, 1'b1, 1'b0, 1'b0}));
        reset = 1'b0;
        sym_log.delete();
        send_block(4, 0, 0, 0, 0, 0);
        wait_idle("post_reset");
        check("post_reset_nsym", 64'(sym_log.size()), 64'd2);
        check("post_reset_dc", (sym_log.size() > 0) ? 64'(sym_log[0]) : 64'h3FFFF, 64'(s_dc(0, 4)));
        check("post_reset_eob", (sym_log.size() > 1) ? 64'(sym_log[1]) : 64'h3FFFF, 64'(s_eob(0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
